// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core-side request/grant/done ports and SRAM bus of the memory arbiter
interface mem_arbiter_if #(parameter int AW = 32);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [1:0]    d_size;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_done;
  logic          d_err;
  logic [31:0]   rdata;
  logic          sram_cs;
  logic          sram_oe;
  logic          sram_rwr;
  logic [AW-1:0] sram_addr;
  logic [1:0]    sram_dsize;
  logic [31:0]   sram_wdata;
  logic          sram_wdata_oe;
  logic [31:0]   sram_rdata;
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_size, d_wdata, sram_rdata,
    output if_gnt, if_done, d_gnt, d_done, d_err, rdata,
           sram_cs, sram_oe, sram_rwr, sram_addr, sram_dsize, sram_wdata, sram_wdata_oe
  );
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_size, d_wdata, sram_rdata,
    input  if_gnt, if_done, d_gnt, d_done, d_err, rdata,
           sram_cs, sram_oe, sram_rwr, sram_addr, sram_dsize, sram_wdata, sram_wdata_oe
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM between fetch and load/store, one access at a time.
// MEM_ARB_RR_EN selects round-robin tie-breaking instead of data priority with MAX_WAIT starvation limit.
module mem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int AW = 32
) (
  input logic clk,
  input logic rts,
  mem_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD, WR, WREC, ERR} state_t;
  state_t state, state_n;
  logic [AW-1:0] addr_q;
  logic [1:0] size_q;
  logic [31:0] wdata_q;
  logic own_d;
  logic pick_d, if_g, d_g, mis;
  assign mis = (bus.d_size == 2'd1 && bus.d_addr[0]) || (bus.d_size[1] && bus.d_addr[1:0] != 2'b00);
`ifdef MEM_ARB_RR_EN
  logic rr_d;
  assign pick_d = bus.d_req && (!bus.if_req || rr_d);
  always_ff @(posedge clk)
    if (rts) rr_d <= 1'b1;
    else if (if_g || d_g) rr_d <= if_g;
`else
  logic [3:0] cnt;
  assign pick_d = bus.d_req && (!bus.if_req || cnt != 4'(MAX_WAIT));
  always_ff @(posedge clk)
    if (rts || if_g) cnt <= 4'd0;
    else if (d_g && bus.if_req && cnt != 4'(MAX_WAIT)) cnt <= cnt + 4'd1;
`endif
  always_ff @(posedge clk)
    state <= rts ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if_g = 1'b0;
    d_g = 1'b0;
    bus.sram_cs = 1'b1;
    bus.sram_oe = 1'b1;
    bus.sram_rwr = 1'b1;
    bus.sram_wdata_oe = 1'b0;
    bus.sram_addr = '0;
    bus.sram_dsize = 2'd3;
    bus.sram_wdata = 32'd0;
    case (state)
      IDLE: begin
        d_g = !rts && pick_d;
        if_g = !rts && bus.if_req && !pick_d;
        state_n = if_g ? RD : !d_g ? IDLE : mis ? ERR : bus.d_we ? WR : RD;
      end
      RD: begin
        bus.sram_cs = 1'b0;
        bus.sram_oe = 1'b0;
        bus.sram_addr = addr_q;
        bus.sram_dsize = size_q;
        state_n = IDLE;
      end
      WR, WREC: begin
        bus.sram_cs = 1'b0;
        bus.sram_rwr = state == WREC;
        bus.sram_wdata_oe = 1'b1;
        bus.sram_addr = addr_q;
        bus.sram_dsize = size_q;
        bus.sram_wdata = wdata_q;
        state_n = state == WR ? WREC : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.if_gnt = if_g;
  assign bus.d_gnt = d_g;
  always_ff @(posedge clk)
    if (rts) begin
      addr_q <= '0;
      size_q <= 2'd3;
      wdata_q <= 32'd0;
      own_d <= 1'b0;
      bus.rdata <= 32'd0;
      bus.if_done <= 1'b0;
      bus.d_done <= 1'b0;
      bus.d_err <= 1'b0;
    end else begin
      if (if_g) begin
        addr_q <= bus.if_addr;
        size_q <= 2'd3;
        own_d <= 1'b0;
      end else if (d_g) begin
        addr_q <= bus.d_addr;
        size_q <= bus.d_size[1] ? 2'd3 : bus.d_size;
        wdata_q <= bus.d_wdata;
        own_d <= 1'b1;
      end
      if (state == RD) bus.rdata <= bus.sram_rdata;
      bus.if_done <= state == RD && !own_d;
      bus.d_done <= (state == RD && own_d) || state == WREC || state == ERR;
      bus.d_err <= state == ERR;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random accesses against a byte-level memory reference and arbitration rules
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rts = 1'b1;
  always #5 clk = ~clk;
  mem_arbiter_if #(.AW(32)) bus();
  mem_arbiter #(.MAX_WAIT(4), .AW(32)) dut (.clk(clk), .rts(rts), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [31:0] sram_m [64];
  logic inited = 1'b0;
  logic [7:0] ref_mem [256];
  logic [31:0] last_rdata = 32'd0;
  logic [5:0] exp_order;
  assign bus.sram_rdata = sram_m[bus.sram_addr[7:2]];
  always @(posedge clk)
    if (!inited) begin
      for (int i = 0; i < 64; i++) sram_m[i] <= (i == 4) ? 32'h00100093 : 32'h0;
      inited <= 1'b1;
    end else if (!bus.sram_cs && !bus.sram_rwr) begin
      case (bus.sram_dsize)
        2'd0: sram_m[bus.sram_addr[7:2]][8*bus.sram_addr[1:0] +: 8] <= bus.sram_wdata[7:0];
        2'd1: sram_m[bus.sram_addr[7:2]][16*bus.sram_addr[1] +: 16] <= bus.sram_wdata[15:0];
        default: sram_m[bus.sram_addr[7:2]] <= bus.sram_wdata;
      endcase
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a[7:0]) & ~3;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction
  task automatic idle_chk(input string tag);
    chk({tag, "_ctl"}, {23'd0, bus.sram_cs, bus.sram_oe, bus.sram_rwr, bus.sram_wdata_oe,
        bus.if_gnt, bus.if_done, bus.d_gnt, bus.d_done, bus.d_err}, 32'b1_1100_0000);
    chk({tag, "_addr"}, bus.sram_addr, 32'd0);
    chk({tag, "_dsize"}, {30'd0, bus.sram_dsize}, 32'd3);
    chk({tag, "_wdata"}, bus.sram_wdata, 32'd0);
    chk({tag, "_rdata"}, bus.rdata, 32'd0);
  endtask
  task automatic reset_dut();
    @(posedge clk); #1;
    rts = 1'b1; bus.if_req = 1'b0; bus.d_req = 1'b0;
    @(posedge clk); #1;
    rts = 1'b0;
    last_rdata = 32'd0;
  endtask
  task automatic f_access(input logic [31:0] a);
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = a; #1;
    for (int n = 0; n < 20 && !bus.if_gnt; n++) begin @(posedge clk); #2; end
    chk("if_gnt", {31'd0, bus.if_gnt}, 32'd1);
    @(posedge clk); #1;
    bus.if_req = 1'b0; #1;
    chk("f_rd_ctl", {29'd0, bus.sram_cs, bus.sram_oe, bus.sram_rwr}, 32'b001);
    chk("f_rd_addr", bus.sram_addr, a);
    chk("f_rd_dsize", {30'd0, bus.sram_dsize}, 32'd3);
    @(posedge clk); #2;
    chk("if_done", {31'd0, bus.if_done}, 32'd1);
    chk("if_rdata", bus.rdata, ref_word(a));
    last_rdata = ref_word(a);
  endtask
  task automatic d_access(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic mis;
    logic [1:0] esz;
    int b;
    mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
    esz = sz == 2'd0 ? 2'd0 : sz == 2'd1 ? 2'd1 : 2'd3;
    b = int'(a[7:0]);
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_size = sz; bus.d_wdata = wd; #1;
    for (int n = 0; n < 20 && !bus.d_gnt; n++) begin @(posedge clk); #2; end
    chk("d_gnt", {30'd0, bus.d_gnt, bus.if_gnt}, 32'b10);
    @(posedge clk); #1;
    bus.d_req = 1'b0; #1;
    if (mis) begin
      chk("err_cs", {31'd0, bus.sram_cs}, 32'd1);
      @(posedge clk); #2;
      chk("err_done", {30'd0, bus.d_done, bus.d_err}, 32'b11);
      chk("err_rdata", bus.rdata, last_rdata);
    end else if (we) begin
      chk("wr_ctl", {28'd0, bus.sram_cs, bus.sram_oe, bus.sram_rwr, bus.sram_wdata_oe}, 32'b0101);
      chk("wr_addr", bus.sram_addr, a);
      chk("wr_dsize", {30'd0, bus.sram_dsize}, {30'd0, esz});
      chk("wr_wdata", bus.sram_wdata, wd);
      @(posedge clk); #2;
      chk("wrec_ctl", {29'd0, bus.sram_cs, bus.sram_rwr, bus.sram_wdata_oe}, 32'b011);
      @(posedge clk); #2;
      chk("wr_done", {30'd0, bus.d_done, bus.d_err}, 32'b10);
      ref_mem[b] = wd[7:0];
      if (sz != 2'd0) ref_mem[b+1] = wd[15:8];
      if (sz[1]) begin ref_mem[b+2] = wd[23:16]; ref_mem[b+3] = wd[31:24]; end
    end else begin
      chk("ld_ctl", {29'd0, bus.sram_cs, bus.sram_oe, bus.sram_rwr}, 32'b001);
      chk("ld_addr", bus.sram_addr, a);
      chk("ld_dsize", {30'd0, bus.sram_dsize}, {30'd0, esz});
      @(posedge clk); #2;
      chk("ld_done", {30'd0, bus.d_done, bus.d_err}, 32'b10);
      chk("ld_rdata", bus.rdata, ref_word(a));
      last_rdata = ref_word(a);
    end
  endtask
  initial begin
    int k;
    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_size = 2'd0; bus.d_wdata = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_mem[16] = 8'h93; ref_mem[18] = 8'h10;
    repeat (3) @(posedge clk);
    #2;
    idle_chk("reset");
    @(posedge clk); #1;
    rts = 1'b0;
    f_access(32'h10);
    d_access(1'b1, 32'h20, 2'd2, 32'hDEADBEEF);
    d_access(1'b0, 32'h20, 2'd2, 32'h0);
    d_access(1'b0, 32'h21, 2'd1, 32'h0);
    d_access(1'b1, 32'h22, 2'd2, 32'h11111111);
    d_access(1'b1, 32'h23, 2'd0, 32'h00000055);
    d_access(1'b1, 32'h26, 2'd1, 32'h0000CAFE);
    d_access(1'b0, 32'h20, 2'd3, 32'h0);
    d_access(1'b0, 32'h24, 2'd0, 32'h0);
    for (int i = 0; i < 40; i++)
      if ($urandom_range(0, 3) == 0) f_access({24'd0, 6'($urandom_range(0, 63)), 2'b00});
      else d_access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), $urandom);
`ifdef MEM_ARB_RR_EN
    exp_order = 6'b101010;
`else
    exp_order = 6'b010000;
`endif
    reset_dut();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40; bus.d_size = 2'd2;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      #1;
      if (bus.d_gnt || bus.if_gnt) begin
        chk("one_gnt", {31'd0, bus.d_gnt && bus.if_gnt}, 32'd0);
        chk("order", {31'd0, bus.if_gnt}, {31'd0, exp_order[k]});
        k++;
      end
      @(posedge clk); #1;
    end
    chk("order_cnt", k, 6);
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    repeat (4) @(posedge clk);
    reset_dut();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20; bus.d_size = 2'd2;
    bus.if_req = 1'b1; bus.if_addr = 32'h10; #1;
    chk("tie_gnt", {30'd0, bus.d_gnt, bus.if_gnt}, 32'b10);
    @(posedge clk); #1;
    bus.d_req = 1'b0; #1;
    chk("tie_rd_nognt", {31'd0, bus.if_gnt}, 32'd0);
    @(posedge clk); #2;
    chk("tie_done_gnt", {30'd0, bus.d_done, bus.if_gnt}, 32'b11);
    chk("tie_rdata", bus.rdata, ref_word(32'h20));
    @(posedge clk); #1;
    bus.if_req = 1'b0; #1;
    chk("tie_f_addr", bus.sram_addr, 32'h10);
    @(posedge clk); #2;
    chk("tie_if_done", {31'd0, bus.if_done}, 32'd1);
    chk("tie_if_rdata", bus.rdata, ref_word(32'h10));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("tie_quiet", {30'd0, bus.if_gnt || bus.d_gnt, bus.sram_cs}, 32'b01);
    end
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h10; #1;
    chk("rst_gnt", {31'd0, bus.if_gnt}, 32'd1);
    @(posedge clk); #1;
    rts = 1'b1; #1;
    chk("rst_in_rd", {31'd0, bus.sram_cs}, 32'd0);
    @(posedge clk); #2;
    idle_chk("rst_rd");
    @(posedge clk); #1;
    rts = 1'b0; #1;
    chk("rst_resume", {31'd0, bus.if_gnt}, 32'd1);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(posedge clk); #2;
    chk("rst_if_done", {31'd0, bus.if_done}, 32'd1);
    chk("rst_if_rdata", bus.rdata, ref_word(32'h10));
    last_rdata = ref_word(32'h10);
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h30; bus.d_size = 2'd3; bus.d_wdata = 32'h12345678; #1;
    chk("drop_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.if_req = 1'b1; #1;
    chk("drop_wr", {30'd0, bus.if_gnt, bus.sram_rwr}, 32'b00);
    @(posedge clk); #1;
    bus.if_req = 1'b0; #1;
    chk("drop_wrec", {30'd0, bus.if_gnt, bus.sram_rwr}, 32'b01);
    @(posedge clk); #2;
    chk("drop_d_done", {31'd0, bus.d_done}, 32'd1);
    {ref_mem[51], ref_mem[50], ref_mem[49], ref_mem[48]} = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("drop_quiet", {30'd0, bus.if_gnt, bus.sram_cs}, 32'b01);
    end
    d_access(1'b0, 32'h30, 2'd2, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared SRAM between the core's instruction-fetch requester and its load/store requester.
- One access in flight at a time. Each access uses a request/grant/done handshake per port.
- The block drives the SRAM control, address, size and tri-state write-data lines, and returns read data and alignment errors.
- It sits between the core control logic and the sram instance and replaces the core's direct address/data muxing.

Parameters:
- MAX_WAIT, 4: consecutive data grants allowed while fetch is pending before fetch is forced to win. Legal range 1..15.
- AW, 32: address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rts  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  AW  fetch byte address; always a word read.
- if_gnt  out  1  fetch request accepted (one-cycle pulse).
- if_done  out  1  fetch data valid on rdata (one-cycle pulse).
- d_req  in  1  load/store request; held with d_* until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data byte address.
- d_size  in  2  0 = byte, 1 = half, 2 or 3 = word.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted (pulse).
- d_done  out  1  data access complete (pulse); rdata valid if load.
- d_err  out  1  misaligned; valid only with d_done.
- rdata  out  32  registered read data.
- sram_cs  out  1  chip select, active-low.
- sram_oe  out  1  output enable, active-low.
- sram_rwr  out  1  1 = read, 0 = write.
- sram_addr  out  AW  SRAM address.
- sram_dsize  out  2  SRAM size code: 0, 1 or 3.
- sram_wdata  out  32  write data.
- sram_wdata_oe  out  1  drive enable for the external tri-state buffer.
- sram_rdata  in  32  SRAM data bus, sampled on reads.

Behaviour:
- Reset / IDLE output values:
  - sram_cs=1, sram_oe=1, sram_rwr=1, sram_wdata_oe=0.
  - sram_addr=0, sram_dsize=3, sram_wdata=0.
  - All gnt/done/err outputs 0; rdata=0.
  - Starvation counter 0; round-robin pointer set to favour data.
- States: IDLE, RD, WR, WREC, ERR.
- IDLE, arbitration:
  - Arbitration is combinational from the reqs; gnt is asserted in the same cycle.
  - The winner's addr/size/we/wdata and an owner bit are latched on that edge.
  - Next state is RD (load or fetch), WR (store), or ERR (misaligned).
- Priority:
  - Data beats fetch, unless the starvation counter equals MAX_WAIT; then fetch wins.
  - The counter increments on each d_gnt while if_req=1 and saturates at MAX_WAIT.
  - The counter clears on if_gnt.
- Size mapping: a d_size value of 2 maps to sram_dsize 3. Fetch always uses size 3.
- Alignment checks:
  - Half access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]!=0 is misaligned.
- RD state (1 cycle):
  - sram_cs=0, sram_oe=0, sram_rwr=1, latched address and size driven.
  - sram_rdata is captured into rdata at the end of the cycle. rdata holds until the next read.
  - The owner's done pulses in the following cycle, and the arbiter is back in IDLE in that cycle.
  - Read latency from gnt to done: 2 cycles. Peak throughput: 1 read per 2 cycles.
- WR state (1 cycle): sram_cs=0, sram_rwr=0, sram_wdata_oe=1, sram_oe=1.
- WREC state (1 cycle):
  - sram_rwr=1 and sram_wdata_oe=1 (data held for hold time); sram_cs=0.
  - d_done pulses in the cycle after WREC. Write latency from gnt to done: 3 cycles.
- ERR state (1 cycle):
  - No SRAM activity (cs stays 1).
  - d_done=1 and d_err=1 in the next cycle; rdata unchanged.
- Requests arriving outside IDLE: gnt stays low. The requester keeps req high until granted.
- A req dropped before gnt is legal and causes no access.
- Both reqs asserted in the same IDLE cycle: exactly one gnt, per the priority rules. The loser is granted at the next IDLE.
- gnt and done for the same port never assert in the same cycle as each other's state change. A new gnt may coincide with the previous done (the IDLE cycle).
- Reset mid-access:
  - The next cycle has the idle outputs; no done pulse for the aborted access.
  - A write in WR may be truncated, and memory contents are then undefined for that address.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- With the macro defined:
  - Fixed priority and the starvation counter are removed.
  - A 1-bit round-robin pointer selects which port wins a tie; after any grant the pointer favours the other port.
  - A lone requester always wins.
- Without the macro: fixed data priority with the MAX_WAIT starvation limit, as above.

Test Plan:
- Reset, then if_req=1 with if_addr=0x10 and SRAM word 0x00100093:
  - if_gnt at cycle 0; RD with sram_addr=0x10, cs=0, oe=0 at cycle 1.
  - if_done=1 and rdata=0x00100093 at cycle 2.
- Store: d_we=1, d_addr=0x20, d_size=2, d_wdata=0xDEADBEEF:
  - WR with rwr=0, dsize=3, wdata_oe=1; WREC with rwr=1, wdata_oe=1; d_done in cycle 3.
  - A later load from 0x20 returns 0xDEADBEEF.
- Misaligned: d_size=1, d_addr=0x21 → no cs assertion, d_done=1 and d_err=1 two cycles after d_gnt.
- Starvation (MAX_WAIT=4): if_req and d_req held continuously → grant order d,d,d,d,if,d…
  - With MEM_ARB_RR_EN defined: order d,if,d,if…
- Reset in RD: rts asserted during RD → no if_done, all outputs at idle values next cycle. Arbitration resumes on the following cycle.
- Simultaneous d_req and if_req released one cycle after d_gnt → exactly one fetch access follows, with if_gnt at the next IDLE.
